// File: rtl/aes_scheduler_if.sv
// Bundle of requester, core and response signals around the AES scheduler.
// The scheduler uses the slave view; whatever drives it uses the master view.
interface aes_scheduler_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_enc;
    logic [2:0]   req_keySize0;
    logic [2:0]   req_keySize1;
    logic [0:127] req_msg0;
    logic [0:127] req_msg1;

    logic         core_start;
    logic         core_encOrDec;
    logic [2:0]   core_keySize;
    logic [0:127] core_msg;
    logic         core_doneE;
    logic         core_doneD;
    logic [0:127] core_msgOutE;
    logic [0:127] core_msgOutD;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic         resp_err;
    logic [0:127] resp_msg;

    logic         busy;

    modport slave (
        input  req_valid, req_enc, req_keySize0, req_keySize1, req_msg0, req_msg1,
        input  core_doneE, core_doneD, core_msgOutE, core_msgOutD,
        input  resp_ready,
        output req_ready,
        output core_start, core_encOrDec, core_keySize, core_msg,
        output resp_valid, resp_id, resp_err, resp_msg,
        output busy
    );

    modport master (
        output req_valid, req_enc, req_keySize0, req_keySize1, req_msg0, req_msg1,
        output core_doneE, core_doneD, core_msgOutE, core_msgOutD,
        output resp_ready,
        input  req_ready,
        input  core_start, core_encOrDec, core_keySize, core_msg,
        input  resp_valid, resp_id, resp_err, resp_msg,
        input  busy
    );
endinterface

// File: rtl/aes_scheduler.sv
// Round-robin scheduler sharing one AES encrypt/decrypt core pair between two
// requesters, with illegal-key rejection and a bounded wait for core completion.
module aes_scheduler #(
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    aes_scheduler_if.slave bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t       state;
    logic         lastId;
    logic [7:0]   timer;

    logic [1:0]   grant;
    logic         gId;
    logic [2:0]   gKeySize;
    logic [0:127] gMsg;
    logic         done;
    logic [0:127] doneMsg;

    // Grant is only offered in IDLE; with both requesting, the one not served last wins.
    always_comb begin
        grant    = 2'b00;
        gId      = 1'b0;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   begin grant = 2'b01; gId = 1'b0; end
                2'b10:   begin grant = 2'b10; gId = 1'b1; end
                2'b11:   begin gId = ~lastId; grant = lastId ? 2'b01 : 2'b10; end
                default: begin grant = 2'b00; gId = 1'b0; end
            endcase
        end
        gKeySize = gId ? bus.req_keySize1 : bus.req_keySize0;
        gMsg     = gId ? bus.req_msg1     : bus.req_msg0;
    end

    assign bus.req_ready = grant;

    // Only the flag of the direction actually started may complete the operation.
    assign done    = bus.core_encOrDec ? bus.core_doneE   : bus.core_doneD;
    assign doneMsg = bus.core_encOrDec ? bus.core_msgOutE : bus.core_msgOutD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            lastId            <= 1'b1;
            timer             <= 8'd0;
            bus.core_start    <= 1'b0;
            bus.core_encOrDec <= 1'b0;
            bus.core_keySize  <= 3'd0;
            bus.core_msg      <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_id       <= 1'b0;
            bus.resp_err      <= 1'b0;
            bus.resp_msg      <= '0;
            bus.busy          <= 1'b0;
        end else begin
            bus.core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        bus.core_encOrDec <= bus.req_enc[gId];
                        bus.core_keySize  <= gKeySize;
                        bus.core_msg      <= gMsg;
                        bus.resp_id       <= gId;
                        bus.busy          <= 1'b1;
                        if (gKeySize > 3'd2) begin
                            // Illegal key size never reaches the core.
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_msg   <= '0;
                        end else begin
                            state          <= START;
                            bus.core_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                    timer <= 8'd0;
                end
                WAIT: begin
                    // Done takes priority over an expiring timer.
                    if (done) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_msg   <= doneMsg;
                    end else if (timer == TIMEOUT_C) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_msg   <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        lastId         <= bus.resp_id;
                        bus.resp_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes_scheduler.md
AES_SCHEDULER -- requirements
Module: aes_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum core cycles waited for done before an error response (range 1..255).
REQ-002 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  in  2  request valid; bit 0 = requester 0, bit 1 = requester 1.
REQ-005 Port: req_ready  out  2  request accepted this cycle, per requester.
REQ-006 Port: req_enc  in  2  per requester: 1 = encrypt, 0 = decrypt.
REQ-007 Port: req_keySize0, req_keySize1  in  3 each  key-size code: 0 = 128-bit, 1 = 192-bit, 2 = 256-bit, others illegal.
REQ-008 Port: req_msg0, req_msg1  in  128 each  input block, bit 0 = MSB.
REQ-009 Port: core_start  out  1  one-cycle start pulse to the shared encrypt/decrypt core pair.
REQ-010 Port: core_encOrDec  out  1  core direction; core_keySize  out  3; core_msg  out  128.
REQ-011 Port: core_doneE, core_doneD  in  1 each  core completion flags.
REQ-012 Port: core_msgOutE, core_msgOutD  in  128 each  core results.
REQ-013 Port: resp_valid  out  1; resp_ready  in  1; resp_id  out  1  requester served; resp_err  out  1; resp_msg  out  128.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 The block SHALL use FSM states IDLE, START, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL assert combinationally for exactly one requester (grant g) when any req_valid is high; req_ready SHALL be 0 in all other states.
REQ-017 Arbitration SHALL be round-robin: with both valid, g = NOT last_id; with one valid, g is that requester.
REQ-018 On acceptance, the block SHALL register op, keySize, and msg of g into core_encOrDec/core_keySize/core_msg and latch resp_id = g.
REQ-019 If the accepted keySize > 2, the FSM SHALL go IDLE->RESP with resp_err = 1 and resp_msg = 0, and core_start SHALL NOT pulse.
REQ-020 Otherwise the FSM SHALL go IDLE->START; START SHALL assert core_start for exactly one cycle and then go to WAIT, clearing the 8-bit timer.
REQ-021 In WAIT, done = core_doneE if core_encOrDec = 1, else core_doneD; the flag of the other direction SHALL be ignored.
REQ-022 When done = 1 in WAIT, the block SHALL capture the matching core_msgOut into resp_msg, set resp_err = 0, and go to RESP on the next cycle.
REQ-023 The timer SHALL increment each WAIT cycle without done; when timer == TIMEOUT and done = 0, the block SHALL go to RESP with resp_err = 1 and resp_msg = 0.
REQ-024 Done and timeout in the same cycle SHALL resolve as done (no error).
REQ-025 In RESP, resp_valid = 1 with resp_id/resp_err/resp_msg stable until resp_ready = 1; on that cycle the block SHALL set last_id = resp_id and return to IDLE.
REQ-026 Minimum latency from acceptance to resp_valid SHALL be 3 cycles (START, WAIT with done, RESP).
REQ-027 core_encOrDec, core_keySize, and core_msg SHALL hold stable from START until the next acceptance.
REQ-028 Back-to-back operation: a new request SHALL be accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-029 On rst = 1 at a clock edge, state SHALL be IDLE, last_id = 1, and timer = 0; req_ready, core_start, resp_valid, resp_err, and busy SHALL be 0; core_msg and resp_msg SHALL be 0; core_keySize and core_encOrDec SHALL be 0.
REQ-030 rst mid-operation SHALL abandon the transaction with no response; a later core done SHALL be ignored while in IDLE.

Verification
REQ-031 Req0 encrypts "This is a test!!" with keySize 0; core model raises doneE 10 cycles after start -> one core_start pulse, resp_valid with resp_id = 0, resp_err = 0, resp_msg = core_msgOutE.
REQ-032 Both requesters are held valid for 4 transactions after reset -> grant order 0,1,0,1.
REQ-033 Req1 requests decrypt with keySize 3 -> no core_start, resp_err = 1, resp_msg = 0, resp_id = 1.
REQ-034 With TIMEOUT = 5 and the core never done -> resp_err = 1 after 6 WAIT cycles; the block then accepts the next request.
REQ-035 Decrypt op with a spurious doneE pulse followed by doneD -> resp_msg = core_msgOutD, captured only on doneD; resp_ready held low 7 cycles -> outputs stable throughout.
REQ-036 rst asserted during WAIT -> next cycle all outputs match REQ-029; a following core_doneD produces no resp_valid.
